// File: rtl/pixel_addr_decoder_pkg.sv
// pixel_addr_pkg: shared geometry defaults, tap constants and the decoder state type.
package pixel_addr_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 640;
  localparam int ADDR_W = 19;
  localparam int ROW_W = 10;
  localparam int COL_W = 10;
  localparam int PIX_COUNT = IMG_W * IMG_H;
  localparam int TAP_W = 4;
  localparam logic [TAP_W-1:0] TAP_NONE = '0;
  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;
endpackage

// File: rtl/pixel_addr_decoder_if.sv
// pixel_addr_if: request/result handshake bundle between the address stream and the window logic.
interface pixel_addr_if #(
  parameter int ADDR_W = pixel_addr_pkg::ADDR_W,
  parameter int ROW_W = pixel_addr_pkg::ROW_W,
  parameter int COL_W = pixel_addr_pkg::COL_W,
  parameter int TAP_W = pixel_addr_pkg::TAP_W
);
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [ROW_W-1:0] in_base_row;
  logic [COL_W-1:0] in_base_col;
  logic out_valid;
  logic out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [TAP_W-1:0] out_tap;
  logic out_hit;
  logic out_oob;
  modport master (
    output in_valid, in_addr, in_base_row, in_base_col, out_ready,
    input in_ready, out_valid, out_row, out_col, out_tap, out_hit, out_oob
  );
  modport slave (
    input in_valid, in_addr, in_base_row, in_base_col, out_ready,
    output in_ready, out_valid, out_row, out_col, out_tap, out_hit, out_oob
  );
endinterface

// File: rtl/pixel_addr_decoder_addr_div_by_width.sv
// addr_div_by_width: restoring shift-subtract divide by a constant width, one quotient bit per cycle.
module addr_div_by_width #(
  parameter int DIVISOR = 640,
  parameter int ADDR_W = 19,
  parameter int ROW_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dividend,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  quot,
  output logic [ADDR_W-1:0] rem
);
  localparam int KW = $clog2(ROW_W + 1);
  localparam int WW = ADDR_W + ROW_W;
  logic [KW-1:0] k;
  logic [WW-1:0] sh;
  logic fit;
  assign sh = WW'(DIVISOR) << k;
  assign fit = {{ROW_W{1'b0}}, rem} >= sh;
  // done marks the cycle performing the k=0 step; results are final after this edge
  assign done = busy & (k == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      quot <= '0;
      k <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem <= dividend;
      quot <= '0;
      k <= KW'(ROW_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (fit) begin
        rem <= rem - sh[ADDR_W-1:0];
        quot <= quot | (ROW_W'(1) << k);
      end
      k <= done ? '0 : k - 1'b1;
      busy <= ~done;
    end
endmodule

// File: rtl/pixel_addr_decoder.sv
// pixel_addr_decoder: linear address -> (row, col) plus 3x3 window tap lookup, one request in flight.
module pixel_addr_decoder #(
  parameter int IMG_W = pixel_addr_pkg::IMG_W,
  parameter int IMG_H = pixel_addr_pkg::IMG_H,
  parameter int ADDR_W = pixel_addr_pkg::ADDR_W,
  parameter int ROW_W = pixel_addr_pkg::ROW_W,
  parameter int COL_W = pixel_addr_pkg::COL_W
) (
  input logic clk,
  input logic rst,
  pixel_addr_if.slave bus
);
  import pixel_addr_pkg::*;
  localparam int PIX = IMG_W * IMG_H;
  state_t state, state_nx;
  logic [ROW_W-1:0] base_row, quot;
  logic [COL_W-1:0] base_col;
  logic [ADDR_W-1:0] rem;
  logic [ROW_W:0] dr;
  logic [ADDR_W:0] dc;
  logic [TAP_W-1:0] tap;
  logic accept, oob, busy, done, hit;
  assign bus.in_ready = state == IDLE;
  assign accept = bus.in_valid & bus.in_ready;
  assign oob = {1'b0, bus.in_addr} >= (ADDR_W + 1)'(PIX);
  addr_div_by_width #(.DIVISOR(IMG_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(accept & ~oob),
    .dividend(bus.in_addr),
    .busy(busy),
    .done(done),
    .quot(quot),
    .rem(rem)
  );
  // two's-complement offsets from the anchor; a set sign bit means left of / above the window
  assign dr = {1'b0, quot} - {1'b0, base_row};
  assign dc = {1'b0, rem} - {1'b0, ADDR_W'(base_col)};
  assign hit = ~dr[ROW_W] & (dr[ROW_W-1:0] < ROW_W'(3)) & ~dc[ADDR_W] & (dc[ADDR_W-1:0] < ADDR_W'(3));
  assign tap = hit ? TAP_W'(3 * dr[1:0]) + TAP_W'(dc[1:0]) : TAP_NONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = oob ? DONE : DIV;
      DIV: state_nx = done ? FIN : (busy ? DIV : IDLE);
      FIN: state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_row <= '0;
      base_col <= '0;
      bus.out_valid <= 1'b0;
      bus.out_row <= '0;
      bus.out_col <= '0;
      bus.out_tap <= TAP_NONE;
      bus.out_hit <= 1'b0;
      bus.out_oob <= 1'b0;
    end else begin
      if (accept) begin
        base_row <= bus.in_base_row;
        base_col <= bus.in_base_col;
      end
      if (accept & oob) begin
        bus.out_valid <= 1'b1;
        bus.out_row <= '0;
        bus.out_col <= '0;
        bus.out_tap <= TAP_NONE;
        bus.out_hit <= 1'b0;
        bus.out_oob <= 1'b1;
      end else if (state == FIN) begin
        bus.out_valid <= 1'b1;
        bus.out_row <= quot;
        bus.out_col <= rem[COL_W-1:0];
        bus.out_tap <= tap;
        bus.out_hit <= hit;
        bus.out_oob <= 1'b0;
      end else if (state == DONE && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pixel_addr_decoder.sv
// tb_pixel_addr_decoder: directed and randomized requests checked against a divide/modulo reference model.
module tb_pixel_addr_decoder;
  import pixel_addr_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  pixel_addr_if bus ();
  pixel_addr_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int addr, input int br, input int bc,
                                output int row, output int col, output int tap,
                                output int hit, output int oob);
    int dr, dc;
    oob = (addr >= PIX_COUNT) ? 1 : 0;
    row = oob ? 0 : addr / IMG_W;
    col = oob ? 0 : addr % IMG_W;
    dr = row - br;
    dc = col - bc;
    hit = (oob == 0 && dr >= 0 && dr <= 2 && dc >= 0 && dc <= 2) ? 1 : 0;
    tap = hit ? 3 * dr + dc : 0;
  endfunction

  task automatic xact(input int addr, input int br, input int bc, input int hold);
    int row, col, tap, hit, oob, c;
    model(addr, br, bc, row, col, tap, hit, oob);
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_addr = ADDR_W'(addr);
    bus.in_base_row = ROW_W'(br);
    bus.in_base_col = COL_W'(bc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 40) begin
      check("in_ready_busy", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      c++;
    end
    check("latency", c, oob ? 0 : ROW_W + 1);
    for (int i = 0; i <= hold; i++) begin
      check("out_valid", int'(bus.out_valid), 1);
      check("out_row", int'(bus.out_row), row);
      check("out_col", int'(bus.out_col), col);
      check("out_tap", int'(bus.out_tap), tap);
      check("out_hit", int'(bus.out_hit), hit);
      check("out_oob", int'(bus.out_oob), oob);
      check("in_ready_done", int'(bus.in_ready), 0);
      if (i < hold) begin
        bus.in_valid = 1'b1;
        bus.in_addr = ADDR_W'($urandom_range(0, PIX_COUNT - 1));
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", int'(bus.out_valid), 0);
    check("in_ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    int a, r, br, bc, seen;
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_base_row = '0;
    bus.in_base_col = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_row", int'(bus.out_row), 0);
    check("rst_out_col", int'(bus.out_col), 0);
    check("rst_out_tap", int'(bus.out_tap), 0);
    check("rst_out_hit", int'(bus.out_hit), 0);
    check("rst_out_oob", int'(bus.out_oob), 0);
    xact(641, 0, 0, 0);
    xact(0, 0, 0, 0);
    xact(2, 0, 0, 0);
    xact(640, 0, 0, 0);
    xact(1282, 0, 0, 0);
    xact(3, 0, 0, 0);
    xact(409599, 638, 637, 0);
    xact(409600, 638, 637, 0);
    xact(3205, 5, 5, 0);
    xact(3203, 5, 5, 0);
    xact(4487, 5, 5, 0);
    xact(641, 0, 0, 5);
    xact(1923, 2, 2, 0);
    // abort a transaction in the fourth DIV cycle
    bus.in_valid = 1'b1;
    bus.in_addr = ADDR_W'(641);
    bus.in_base_row = '0;
    bus.in_base_col = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_in_ready", int'(bus.in_ready), 1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    xact(641, 0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      a = (i % 8 == 7) ? int'($urandom_range(PIX_COUNT, 2 ** ADDR_W - 1))
                       : int'($urandom_range(0, PIX_COUNT - 1));
      r = a / IMG_W;
      br = (r - int'($urandom_range(0, 3))) & (2 ** ROW_W - 1);
      bc = ((a % IMG_W) - int'($urandom_range(0, 3))) & (2 ** COL_W - 1);
      if (i % 5 == 4) br = int'($urandom_range(0, 2 ** ROW_W - 1));
      xact(a, br, bc, int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
